sc_fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that lets N_REQ producers share one show-ahead single-clock FIFO.
- Grants one requester at a time for a bounded burst.
- Drives the FIFO's d/we/sclr inputs.
- Back-pressures producers using the FIFO's registered full flag.
- Sits between producer blocks and the FIFO; the FIFO read side is untouched.

---
 rtl/sc_fifo_pkg.sv | 39 +++
 rtl/sc_fifo_wr_arbiter_picker.sv | 28 ++
 rtl/sc_fifo_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_sc_fifo_wr_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_fifo_pkg.sv
// Shared types and helpers for the shared-FIFO write arbiter.
package sc_fifo_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

  localparam int MAX_REQ   = 32;
  localparam int MAX_IDX_W = 5;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic int clog2_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of valid[n-1:0] scanning ptr, ptr+1, ... with explicit wrap at n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input int ptr, input int n);
    rr_pick_t             res;
    int                   cand;
    logic [MAX_IDX_W-1:0] c5;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        cand = ptr + k;
        if (cand >= n) cand = cand - n;
        c5 = cand[MAX_IDX_W-1:0];
        if (!res.found && valid[c5]) begin
          res.found = 1'b1;
          res.idx   = c5;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sc_fifo_wr_arbiter_picker.sv
// Combinational rotate-priority selector: first valid index at or after the start pointer.
module rr_priority_picker
  import sc_fifo_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         valid_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     found_o
);
  localparam int IW = $clog2(N_REQ);

  logic [MAX_REQ-1:0] valid_ext;
  rr_pick_t           pick;

  always_comb begin
    valid_ext             = '0;
    valid_ext[N_REQ-1:0]  = valid_i;
    pick                  = rr_pick(valid_ext, int'(ptr_i), N_REQ);
    found_o               = pick.found;
    idx_o                 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick.idx == MAX_IDX_W'(i)) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/sc_fifo_wr_arbiter.sv
// Round-robin write arbiter letting N_REQ producers share one FIFO write port.
// One arbitration cycle per grant, bursts capped at MAX_BURST, stalls on FIFO full.
module sc_fifo_wr_arbiter
  import sc_fifo_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]       fifo_d,
  output logic                        fifo_we,
  output logic                        fifo_sclr,
  input  logic                        fifo_full,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = clog2_w(MAX_BURST + 1);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            busy_q, busy_d;

  logic [IW-1:0]         pick_idx;
  logic                  pick_found;
  logic                  own_valid, own_last, own_rdy, xfer, rel_grant;
  logic [DATA_WIDTH-1:0] own_data;
  logic [IW-1:0]         next_ptr;

  rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign own_valid = req_valid[grant_id_q];
  assign own_last  = req_last[grant_id_q];

  always_comb begin
    own_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == IW'(i)) own_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Ready also drops while reset is held, so no beat is taken while the FIFO is being cleared.
  assign own_rdy   = (state_q == GRANT) && !fifo_full && !flush && rst_n;
  assign xfer      = own_valid && own_rdy;
  assign rel_grant = !own_valid || (xfer && (own_last || beat_cnt_q == CW'(MAX_BURST - 1)));
  assign next_ptr  = (grant_id_q == IW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    req_ready = '0;
    if (own_rdy) req_ready[grant_id_q] = 1'b1;
  end

  assign fifo_we   = xfer;
  assign fifo_d    = (state_q == GRANT) ? own_data : '0;
  assign fifo_sclr = flush || !rst_n;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;
    if (flush) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_d    = GRANT;
            grant_id_d = pick_idx;
            beat_cnt_d = '0;
            busy_d     = 1'b1;
          end
        end
        GRANT: begin
          if (rel_grant) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            beat_cnt_d = '0;
            rr_ptr_d   = next_ptr;
          end else if (xfer) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_sc_fifo_wr_arbiter.sv
// Bench for sc_fifo_wr_arbiter: vector table, directed corner cases, random run vs. a reference model.
module tb_sc_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n, flush;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   fifo_d;
  logic            fifo_we, fifo_sclr;
  logic            fifo_full = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_d    (fifo_d),
    .fifo_we   (fifo_we),
    .fifo_sclr (fifo_sclr),
    .fifo_full (fifo_full),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // Show-ahead FIFO stand-in with a registered full flag.
  logic [DW-1:0] fq[$];
  int            fdepth = 16;
  logic          rd_en;

  always @(posedge clk) begin
    if (fifo_sclr) fq.delete();
    else begin
      if (rd_en && fq.size() > 0) void'(fq.pop_front());
      if (fifo_we && fq.size() < fdepth) fq.push_back(fifo_d);
    end
    fifo_full <= (fq.size() >= fdepth);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [1:0]   gid;
    logic [N-1:0] ready;
  } arb_vec_t;

  arb_vec_t tbl[8];

  initial begin
    int sent, grants, run, maxrun, gaps;
    int m_owner, m_start, m_gid, m_beats;
    logic          done;
    logic [N-1:0]  e_ready;
    logic          e_we;
    logic [DW-1:0] e_d;

    // Expected owners follow the rotating pointer: each grant ends on last, pointer = owner+1.
    tbl[0] = '{4'b0001, 2'd0, 4'b0001};
    tbl[1] = '{4'b0001, 2'd0, 4'b0001};
    tbl[2] = '{4'b1001, 2'd3, 4'b1000};
    tbl[3] = '{4'b0110, 2'd1, 4'b0010};
    tbl[4] = '{4'b0011, 2'd0, 4'b0001};
    tbl[5] = '{4'b1111, 2'd1, 4'b0010};
    tbl[6] = '{4'b1100, 2'd2, 4'b0100};
    tbl[7] = '{4'b0111, 2'd0, 4'b0001};

    rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_last = '0; req_data = '0; rd_en = 1'b0;
    tick();
    tick();
    settle();
    check("rst_ready", req_ready, 0);
    check("rst_we", fifo_we, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_fifo_d", fifo_d, 0);
    check("rst_sclr", fifo_sclr, 1);
    rst_n = 1'b1;
    #1;
    check("sclr_released", fifo_sclr, 0);

    for (int i = 0; i < N; i++) set_data(i, DW'(8'hA0 + i));
    req_last = '1;
    for (int t = 0; t < 8; t++) begin
      req_valid = tbl[t].valid;
      settle();
      check("tbl_idle_ready", req_ready, 0);
      check("tbl_idle_busy", busy, 0);
      tick();
      settle();
      check("tbl_busy", busy, 1);
      check("tbl_grant_id", grant_id, tbl[t].gid);
      check("tbl_ready", req_ready, tbl[t].ready);
      check("tbl_we", fifo_we, 1);
      check("tbl_fifo_d", fifo_d, 32'hA0 + tbl[t].gid);
      tick();
    end
    req_valid = '0;
    req_last  = '0;

    // Single requester: three beats, last on the third.
    do_flush();
    req_valid = 4'b0001; set_data(0, 8'h11);
    settle();
    check("single_idle_we", fifo_we, 0);
    tick(); settle();
    check("single_busy", busy, 1);
    check("single_we1", fifo_we, 1);
    check("single_d1", fifo_d, 8'h11);
    tick(); set_data(0, 8'h22); settle();
    check("single_d2", fifo_d, 8'h22);
    tick(); set_data(0, 8'h33); req_last = 4'b0001; settle();
    check("single_we3", fifo_we, 1);
    check("single_d3", fifo_d, 8'h33);
    tick(); req_valid = '0; req_last = '0; settle();
    check("single_idle_after", busy, 0);
    check("single_fifo_cnt", fq.size(), 3);
    check("single_fifo_head", fq[0], 8'h11);
    check("single_fifo_tail", fq[2], 8'h33);

    // Burst cap: sole requester 2 never marks last.
    do_flush();
    sent = 0; grants = 0; run = 0; maxrun = 0; gaps = 0;
    for (int c = 0; c < 80 && sent < 10; c++) begin
      req_valid = 4'b0100; set_data(2, DW'(sent));
      settle();
      if (busy && run == 0 && fifo_we) grants++;
      if (!busy && grants > 0) gaps++;
      if (!busy) run = 0;
      if (fifo_we) begin
        sent++; run++;
        if (run > maxrun) maxrun = run;
      end
      tick();
    end
    req_valid = '0;
    check("cap_beats", sent, 10);
    check("cap_grants", grants, 3);
    check("cap_max_run", maxrun, MB);
    check("cap_gaps", gaps, 2);
    check("cap_fifo_cnt", fq.size(), 10);
    check("cap_fifo_last", fq[9], 9);
    tick();

    // Full back-pressure with a 4-entry FIFO and no reads.
    fdepth = 4;
    do_flush();
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      req_valid = (sent < 6) ? 4'b0010 : 4'b0000; set_data(1, DW'(8'h50 + sent));
      settle();
      if (fifo_full) begin
        check("full_ready_low", req_ready, 0);
        check("full_no_we", fifo_we, 0);
      end
      if (fifo_we) sent++;
      tick();
    end
    check("full_writes", sent, 4);
    check("full_flag", fifo_full, 1);
    check("full_hold_grant", busy, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    settle();
    check("full_dropped", fifo_full, 0);
    check("full_resume_we", fifo_we, 1);
    check("full_resume_d", fifo_d, 8'h54);
    check("full_resume_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    settle();
    check("full_fifo_cnt", fq.size(), 4);
    check("full_fifo_tail", fq[3], 8'h54);
    tick();
    fdepth = 16;
    do_flush();

    // Flush mid-burst: pointer moved to 1 first, then grant to requester 3.
    do_reset();
    for (int i = 0; i < N; i++) set_data(i, DW'(8'hA0 + i));
    req_valid = 4'b0001; req_last = 4'b0001;
    tick(); tick();
    req_valid = 4'b1000; req_last = '0;
    tick(); settle();
    check("flush_pre_gid", grant_id, 3);
    check("flush_pre_we", fifo_we, 1);
    tick();
    flush = 1'b1;
    settle();
    check("flush_no_we", fifo_we, 0);
    check("flush_sclr", fifo_sclr, 1);
    check("flush_ready", req_ready, 0);
    tick();
    flush = 1'b0;
    settle();
    check("flush_idle", busy, 0);
    check("flush_gid_kept", grant_id, 3);
    check("flush_fifo_empty", fq.size(), 0);
    req_valid = 4'b1111;
    tick(); settle();
    check("flush_ptr_kept", grant_id, 1);
    req_valid = '0;
    tick();

    // Reset mid-burst.
    req_valid = 4'b1000;
    tick(); settle();
    check("rstmid_pre_gid", grant_id, 3);
    tick();
    rst_n = 1'b0;
    settle();
    check("rstmid_sclr", fifo_sclr, 1);
    tick();
    rst_n = 1'b1; req_valid = '0;
    settle();
    check("rstmid_ready", req_ready, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_gid", grant_id, 0);
    check("rstmid_fifo_empty", fq.size(), 0);
    req_valid = 4'b1111;
    tick(); settle();
    check("rstmid_ptr_zero", grant_id, 0);
    req_valid = '0;
    tick(); tick();

    // Random traffic against a transaction-level model.
    fdepth = 4;
    do_reset();
    m_owner = -1; m_start = 0; m_gid = 0; m_beats = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_last[i]  = ($urandom_range(0, 2) == 0);
        set_data(i, DW'($urandom));
      end
      flush = ($urandom_range(0, 24) == 0);
      rd_en = ($urandom_range(0, 2) == 0);
      settle();
      e_ready = '0; e_we = 1'b0; e_d = '0;
      if (m_owner >= 0) begin
        e_d = req_data[m_owner*DW +: DW];
        if (!fifo_full && !flush) begin
          e_ready[m_owner] = 1'b1;
          e_we = req_valid[m_owner];
        end
      end
      check("rnd_ready", req_ready, e_ready);
      check("rnd_we", fifo_we, e_we);
      check("rnd_fifo_d", fifo_d, e_d);
      check("rnd_busy", busy, (m_owner >= 0));
      check("rnd_grant_id", grant_id, m_gid);
      check("rnd_sclr", fifo_sclr, flush);
      check("rnd_we_vs_full", fifo_we && fifo_full, 0);
      if (flush) begin
        m_owner = -1; m_beats = 0;
      end else if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req_valid[(m_start + k) % N]) begin
            m_owner = (m_start + k) % N;
            m_gid   = m_owner;
            m_beats = 0;
          end
        end
      end else begin
        done = 1'b0;
        if (!req_valid[m_owner]) done = 1'b1;
        else if (e_we) begin
          m_beats++;
          done = req_last[m_owner] || (m_beats == MB);
        end
        if (done) begin
          m_start = (m_owner + 1) % N;
          m_owner = -1;
          m_beats = 0;
        end
      end
      tick();
    end
    flush = 1'b0; req_valid = '0; rd_en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
